// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB receive byte path
package usb_rx_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        DRAIN = 2'd2
    } rx_asm_state_t;

    localparam int USB_PID_W = 4;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SOF   = 8'hA5;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

endpackage

// File: rtl/usb_rx_byte_assembler_if.sv
// rtl/usb_rx_byte_assembler_if.sv - bit stream in, framed byte stream out
interface usb_rx_byte_assembler_if #(
    parameter int LEN_W = 11
);
    logic             in_bit;
    logic             in_valid;
    logic             in_eop;
    logic [7:0]       out_byte;
    logic             out_byte_valid;
    logic             out_sop;
    logic             out_eop;
    logic [LEN_W-1:0] out_len;
    logic             out_pid_err;
    logic             out_err;

    modport master (
        output in_bit, in_valid, in_eop,
        input  out_byte, out_byte_valid, out_sop, out_eop, out_len, out_pid_err, out_err
    );

    modport slave (
        input  in_bit, in_valid, in_eop,
        output out_byte, out_byte_valid, out_sop, out_eop, out_len, out_pid_err, out_err
    );

endinterface

// File: rtl/usb_rx_byte_assembler.sv
// rtl/usb_rx_byte_assembler.sv - SYNC hunt, LSB-first byte assembly, PID check and packet framing
module usb_rx_byte_assembler
    import usb_rx_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int MAX_BYTES      = 1027,
    parameter int LEN_W          = $clog2(MAX_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    nRST,
    usb_rx_byte_assembler_if.slave  rx
);

    localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);

    rx_asm_state_t    state_q, state_d;
    logic [ZW-1:0]    zero_cnt_q, zero_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       out_byte_q, out_byte_d;
    logic             out_byte_valid_q, out_byte_valid_d;
    logic             out_sop_q, out_sop_d;
    logic             out_eop_q, out_eop_d;
    logic [LEN_W-1:0] out_len_q, out_len_d;
    logic             out_pid_err_q, out_pid_err_d;
    logic             out_err_q, out_err_d;
    logic [7:0]       byte_next;

    // Right shift: the first bit on the wire ends up in bit 0
    assign byte_next = {rx.in_bit, shift_q[7:1]};

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q          <= HUNT;
            zero_cnt_q       <= '0;
            bit_cnt_q        <= '0;
            byte_cnt_q       <= '0;
            shift_q          <= '0;
            out_byte_q       <= '0;
            out_byte_valid_q <= 1'b0;
            out_sop_q        <= 1'b0;
            out_eop_q        <= 1'b0;
            out_len_q        <= '0;
            out_pid_err_q    <= 1'b0;
            out_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            zero_cnt_q       <= zero_cnt_d;
            bit_cnt_q        <= bit_cnt_d;
            byte_cnt_q       <= byte_cnt_d;
            shift_q          <= shift_d;
            out_byte_q       <= out_byte_d;
            out_byte_valid_q <= out_byte_valid_d;
            out_sop_q        <= out_sop_d;
            out_eop_q        <= out_eop_d;
            out_len_q        <= out_len_d;
            out_pid_err_q    <= out_pid_err_d;
            out_err_q        <= out_err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        zero_cnt_d       = zero_cnt_q;
        bit_cnt_d        = bit_cnt_q;
        byte_cnt_d       = byte_cnt_q;
        shift_d          = shift_q;
        out_byte_d       = out_byte_q;
        out_byte_valid_d = 1'b0;
        out_sop_d        = 1'b0;
        out_eop_d        = 1'b0;
        out_len_d        = out_len_q;
        out_pid_err_d    = out_pid_err_q;
        out_err_d        = out_err_q;

        case (state_q)
            HUNT: begin
                if (rx.in_valid) begin
                    if (!rx.in_bit) begin
                        if (zero_cnt_q != ZW'(SYNC_MIN_ZEROS)) begin
                            zero_cnt_d = zero_cnt_q + ZW'(1);
                        end
                    end else if (zero_cnt_q == ZW'(SYNC_MIN_ZEROS)) begin
                        state_d       = DATA;
                        out_sop_d     = 1'b1;
                        zero_cnt_d    = '0;
                        bit_cnt_d     = '0;
                        byte_cnt_d    = '0;
                        out_pid_err_d = 1'b0;
                        out_err_d     = 1'b0;
                    end else begin
                        zero_cnt_d = '0;
                    end
                end
            end

            DATA, DRAIN: begin
                // EOP takes priority over a bit arriving in the same cycle
                if (rx.in_eop) begin
                    state_d    = HUNT;
                    out_eop_d  = 1'b1;
                    out_len_d  = byte_cnt_q;
                    out_err_d  = out_err_q || (bit_cnt_q != 3'd0) || (byte_cnt_q == '0);
                    zero_cnt_d = '0;
                    bit_cnt_d  = '0;
                end else if (rx.in_valid && (state_q == DATA)) begin
                    shift_d   = byte_next;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q == LEN_W'(MAX_BYTES)) begin
                            state_d   = DRAIN;
                            out_err_d = 1'b1;
                        end else begin
                            out_byte_d       = byte_next;
                            out_byte_valid_d = 1'b1;
                            byte_cnt_d       = byte_cnt_q + LEN_W'(1);
                            if (byte_cnt_q == '0) begin
                                out_pid_err_d = (byte_next[7:USB_PID_W] != ~byte_next[USB_PID_W-1:0]);
                            end
                        end
                    end
                end
            end

            default: state_d = HUNT;
        endcase
    end

    assign rx.out_byte       = out_byte_q;
    assign rx.out_byte_valid = out_byte_valid_q;
    assign rx.out_sop        = out_sop_q;
    assign rx.out_eop        = out_eop_q;
    assign rx.out_len        = out_len_q;
    assign rx.out_pid_err    = out_pid_err_q;
    assign rx.out_err        = out_err_q;

endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// tb/tb_usb_rx_byte_assembler.sv - randomized bench for usb_rx_byte_assembler against a packet-level model
module tb_usb_rx_byte_assembler;
    import usb_rx_pkg::*;

    localparam int SMZ  = 5;
    localparam int MAXA = 1027;
    localparam int MAXB = 2;
    localparam int LWA  = $clog2(MAXA + 1);
    localparam int LWB  = $clog2(MAXB + 1);

    logic clk = 1'b0;
    logic nRST;
    logic d_bit, d_valid, d_eop;

    always #5 clk = ~clk;

    usb_rx_byte_assembler_if #(.LEN_W(LWA)) ifa ();
    usb_rx_byte_assembler_if #(.LEN_W(LWB)) ifb ();

    assign ifa.in_bit   = d_bit;
    assign ifa.in_valid = d_valid;
    assign ifa.in_eop   = d_eop;
    assign ifb.in_bit   = d_bit;
    assign ifb.in_valid = d_valid;
    assign ifb.in_eop   = d_eop;

    usb_rx_byte_assembler #(.SYNC_MIN_ZEROS(SMZ), .MAX_BYTES(MAXA), .LEN_W(LWA)) dut_a (
        .clk(clk), .nRST(nRST), .rx(ifa));
    usb_rx_byte_assembler #(.SYNC_MIN_ZEROS(SMZ), .MAX_BYTES(MAXB), .LEN_W(LWB)) dut_b (
        .clk(clk), .nRST(nRST), .rx(ifb));

    int n_cmp = 0;
    int n_bad = 0;
    bit rnd_gap = 0;

    // Packet-level model state, one slot per DUT instance
    int m_inpkt[2], m_drain[2], m_zeros[2], m_nbits[2], m_acc[2], m_nbytes[2], m_err[2];
    int e_sop[2], e_bv[2], e_byte[2], e_pid[2], e_eop[2], e_len[2], e_err[2];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_inpkt[k] = 0; m_drain[k] = 0; m_zeros[k] = 0; m_nbits[k] = 0;
            m_acc[k] = 0; m_nbytes[k] = 0; m_err[k] = 0;
            e_sop[k] = 0; e_bv[k] = 0; e_byte[k] = 0; e_pid[k] = 0;
            e_eop[k] = 0; e_len[k] = 0; e_err[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input int maxb, input bit v, input bit b, input bit e);
        e_sop[k] = 0; e_bv[k] = 0; e_eop[k] = 0;
        if (m_inpkt[k] == 0) begin
            if (v) begin
                if (!b) begin
                    m_zeros[k] = (m_zeros[k] < SMZ) ? m_zeros[k] + 1 : SMZ;
                end else if (m_zeros[k] >= SMZ) begin
                    m_inpkt[k] = 1; m_drain[k] = 0; m_zeros[k] = 0; m_nbits[k] = 0;
                    m_acc[k] = 0; m_nbytes[k] = 0; m_err[k] = 0; e_pid[k] = 0; e_sop[k] = 1;
                end else begin
                    m_zeros[k] = 0;
                end
            end
        end else if (e) begin
            e_eop[k] = 1;
            e_len[k] = m_nbytes[k];
            e_err[k] = (m_err[k] != 0 || m_nbits[k] != 0 || m_nbytes[k] == 0) ? 1 : 0;
            m_err[k] = e_err[k];
            m_inpkt[k] = 0; m_zeros[k] = 0; m_nbits[k] = 0; m_acc[k] = 0;
        end else if (v && m_drain[k] == 0) begin
            m_acc[k] = m_acc[k] + (int'(b) << m_nbits[k]);
            m_nbits[k]++;
            if (m_nbits[k] == 8) begin
                if (m_nbytes[k] == maxb) begin
                    m_err[k] = 1; m_drain[k] = 1;
                end else begin
                    m_nbytes[k]++;
                    e_bv[k] = 1;
                    e_byte[k] = m_acc[k];
                    if (m_nbytes[k] == 1)
                        e_pid[k] = (((m_acc[k] >> 4) & 15) != ((~m_acc[k]) & 15)) ? 1 : 0;
                end
                m_nbits[k] = 0; m_acc[k] = 0;
            end
        end
    endtask

    task automatic cmp_one(input string nm, input int k, input int sop, input int bv, input int byt,
                           input int pid, input int eop, input int len, input int err);
        check({nm, "_sop"}, sop, e_sop[k]);
        check({nm, "_byte_valid"}, bv, e_bv[k]);
        check({nm, "_byte"}, byt, e_byte[k]);
        check({nm, "_pid_err"}, pid, e_pid[k]);
        check({nm, "_eop"}, eop, e_eop[k]);
        if (e_eop[k] != 0) begin
            check({nm, "_len"}, len, e_len[k]);
            check({nm, "_err"}, err, e_err[k]);
        end
    endtask

    task automatic cmp_all();
        cmp_one("a", 0, int'(ifa.out_sop), int'(ifa.out_byte_valid), int'(ifa.out_byte),
                int'(ifa.out_pid_err), int'(ifa.out_eop), int'(ifa.out_len), int'(ifa.out_err));
        cmp_one("b", 1, int'(ifb.out_sop), int'(ifb.out_byte_valid), int'(ifb.out_byte),
                int'(ifb.out_pid_err), int'(ifb.out_eop), int'(ifb.out_len), int'(ifb.out_err));
    endtask

    task automatic step(input bit v, input bit b, input bit e);
        d_valid = v; d_bit = b; d_eop = e;
        model_step(0, MAXA, v, b, e);
        model_step(1, MAXB, v, b, e);
        @(posedge clk);
        #1;
        cmp_all();
        d_valid = 1'b0; d_eop = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        if (rnd_gap) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) step(1'b0, 1'b0, 1'b0);
        end
        step(1'b1, b, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] x);
        for (int i = 0; i < 8; i++) send_bit(x[i]);
    endtask

    task automatic send_sync(input int nz);
        for (int i = 0; i < nz; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_eop();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic reset_now();
        nRST = 1'b0;
        d_valid = 1'b0; d_eop = 1'b0; d_bit = 1'b0;
        model_reset();
        #1;
        cmp_all();
        check("rst_err_a", int'(ifa.out_err), 0);
        check("rst_len_a", int'(ifa.out_len), 0);
        @(posedge clk);
        #1;
        nRST = 1'b1;
    endtask

    logic [7:0] pids [8] = '{PID_OUT, PID_IN, PID_SOF, PID_SETUP, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK};

    initial begin
        nRST = 1'b0;
        d_bit = 1'b0; d_valid = 1'b0; d_eop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        reset_now();

        // IN PID packet
        send_sync(7);
        send_byte(8'h69);
        send_eop();
        check("t_in_byte", int'(ifa.out_byte), 'h69);
        check("t_in_len", int'(ifa.out_len), 1);
        check("t_in_err", int'(ifa.out_err), 0);

        // Short SYNC rejected, longer SYNC accepted, bad PID flagged
        send_sync(4);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        send_sync(6);
        send_byte(8'h66);
        send_eop();
        check("t_bad_pid", int'(ifa.out_pid_err), 1);
        check("t_bad_pid_err", int'(ifa.out_err), 0);

        // Partial trailing byte; instance b also overflows its 2-byte limit
        send_sync(5);
        send_byte(8'hC3); send_byte(8'hAA); send_byte(8'h55);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_eop();
        check("t_part_len", int'(ifa.out_len), 3);
        check("t_part_err", int'(ifa.out_err), 1);
        check("t_max_len", int'(ifb.out_len), 2);
        check("t_max_err", int'(ifb.out_err), 1);

        // Gapped input
        rnd_gap = 1;
        send_sync(8);
        send_byte(8'h69);
        send_eop();
        check("t_gap_byte", int'(ifa.out_byte), 'h69);
        rnd_gap = 0;

        // Reset mid-byte, then clean packet
        send_sync(5);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        reset_now();
        repeat (3) step(1'b0, 1'b0, 1'b0);
        send_sync(5);
        send_byte(8'hD2);
        send_eop();
        check("t_post_rst_byte", int'(ifa.out_byte), 'hD2);

        // EOP coincident with a bit that would complete a byte
        send_sync(5);
        send_byte(8'h2D);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("t_coinc_len", int'(ifa.out_len), 1);
        check("t_coinc_err", int'(ifa.out_err), 1);

        // Randomized packets
        for (int p = 0; p < 40; p++) begin
            int nnoise, nbytes, nextra;
            rnd_gap = $urandom_range(0, 1);
            nnoise = $urandom_range(0, 6);
            for (int i = 0; i < nnoise; i++) send_bit(1'($urandom_range(0, 1)));
            send_sync($urandom_range(3, 8));
            nbytes = $urandom_range(0, 4);
            for (int i = 0; i < nbytes; i++) begin
                if (i == 0 && $urandom_range(0, 1) == 1) send_byte(pids[$urandom_range(0, 7)]);
                else send_byte(8'($urandom));
            end
            nextra = $urandom_range(0, 9);
            for (int i = 0; i < nextra; i++) send_bit(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            else step(1'b0, 1'b0, 1'b1);
            repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
